// File: rtl/instr_ram_arb_pkg.sv
// rtl/instr_ram_arb_pkg.sv - shared types for the instruction RAM arbiter
//
// Purpose: response-owner encoding and the request record muxed onto the
// RAM port. The record is sized by the package widths; the top checks at
// elaboration that its own widths match them.
package instr_ram_arb_pkg;

  localparam int ARB_ADDR_WIDTH = 16;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_BE_WIDTH   = ARB_DATA_WIDTH / 8;

  // Which requester the in-flight RAM access belongs to.
  typedef enum logic {
    OWNER_FETCH  = 1'b0,
    OWNER_LOADER = 1'b1
  } owner_e;

  // One RAM access as presented to the wrapper.
  typedef struct packed {
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [ARB_BE_WIDTH-1:0]   be;
    logic [ARB_DATA_WIDTH-1:0] wdata;
  } req_t;

  // The fetch port is read-only: full-word read, no write data.
  function automatic req_t fetch_req(input logic [ARB_ADDR_WIDTH-1:0] addr);
    req_t r;
    r.addr  = addr;
    r.we    = 1'b0;
    r.be    = '1;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/instr_ram_arb_resp.sv
// rtl/instr_ram_arb_resp.sv - response register and read-data demux
//
// Purpose: the RAM answers exactly one cycle after an enabled access, so a
// single valid/owner register is enough to steer each response back to the
// port that issued it.
// Ports:
//   clk, rst           clock, async active-high reset
//   ram_en             an access is issued this cycle
//   owner              1 when the access belongs to the loader port
//   ram_rdata          RAM read data (refers to last cycle's access)
//   m0_rvalid/m0_rdata fetch response
//   m1_rvalid/m1_rdata loader response
module instr_ram_arb_resp
  import instr_ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_en,
  input  logic                  owner,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata
);

  logic   valid_q;
  owner_e owner_q;

  // Reset drops any response still in flight; nothing is emitted afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      owner_q <= OWNER_FETCH;
    end else begin
      valid_q <= ram_en;
      owner_q <= owner ? OWNER_LOADER : OWNER_FETCH;
    end
  end

  assign m0_rvalid = valid_q & (owner_q == OWNER_FETCH);
  assign m1_rvalid = valid_q & (owner_q == OWNER_LOADER);

  // Data is zeroed on the port that does not own the response.
  assign m0_rdata = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata = m1_rvalid ? ram_rdata : '0;

endmodule

// File: rtl/instr_ram_arbiter.sv
// rtl/instr_ram_arbiter.sv - fetch/loader arbiter for the instruction RAM
//
// Purpose: shares the single-port instruction RAM wrapper between the core
// fetch port (m0, fixed priority) and the loader/debug port (m1). m1 is
// forced through after MAX_WAIT consecutive lost cycles, and m1_lock_i
// shuts m0 out completely during program download.
// Ports:
//   clk, rst                 clock, async active-high reset
//   m0_req_i/m0_addr_i       fetch request (read only)
//   m0_gnt_o                 fetch grant, same cycle
//   m0_rvalid_o/m0_rdata_o   fetch response, one cycle after grant
//   m1_req_i/addr/we/be/wdata loader request
//   m1_lock_i                loader lock, blocks every fetch grant
//   m1_gnt_o                 loader grant, same cycle
//   m1_rvalid_o/m1_rdata_o   loader response (reads and writes)
//   ram_*                    RAM wrapper port, 1-cycle read latency
module instr_ram_arbiter
  import instr_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic                    m1_lock_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam logic [CNT_WIDTH-1:0] MAX_WAIT_C = CNT_WIDTH'(MAX_WAIT);

  generate
    if (ADDR_WIDTH != ARB_ADDR_WIDTH || DATA_WIDTH != ARB_DATA_WIDTH) begin : g_width_check
      $error("instr_ram_arbiter widths must match instr_ram_arb_pkg");
    end
    if (MAX_WAIT < 0 || MAX_WAIT > (2**CNT_WIDTH) - 1) begin : g_cnt_check
      $error("instr_ram_arbiter CNT_WIDTH cannot hold MAX_WAIT");
    end
  endgenerate

  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 force1;
  logic                 gnt0;
  logic                 gnt1;
  req_t                 req0;
  req_t                 req1;
  req_t                 ram_req;

  // m1 wins outright when it holds the lock or has starved long enough.
  // With MAX_WAIT=0 the compare is always true, giving m1 strict priority.
  assign force1 = m1_req_i & (m1_lock_i | (wait_cnt >= MAX_WAIT_C));

  // Grants are masked by rst so nothing reaches the RAM while in reset,
  // even though the grant path itself is purely combinational.
  assign gnt1 = ~rst & m1_req_i & (force1 | ~m0_req_i);
  assign gnt0 = ~rst & m0_req_i & ~m1_lock_i & ~gnt1;

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Consecutive cycles m1 asked and lost; any grant or idle cycle restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!m1_req_i || gnt1) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    req1       = '0;
    req1.addr  = m1_addr_i;
    req1.we    = m1_we_i;
    req1.be    = m1_be_i;
    req1.wdata = m1_wdata_i;
  end

  assign req0 = fetch_req(m0_addr_i);

  // Idle cycles present the fetch request with ram_en_o low.
  assign ram_req = gnt1 ? req1 : req0;

  assign ram_en_o    = gnt0 | gnt1;
  assign ram_addr_o  = ram_req.addr;
  assign ram_we_o    = ram_req.we;
  assign ram_be_o    = ram_req.be;
  assign ram_wdata_o = ram_req.wdata;

  instr_ram_arb_resp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_resp (
    .clk       (clk),
    .rst       (rst),
    .ram_en    (ram_en_o),
    .owner     (gnt1),
    .ram_rdata (ram_rdata_i),
    .m0_rvalid (m0_rvalid_o),
    .m0_rdata  (m0_rdata_o),
    .m1_rvalid (m1_rvalid_o),
    .m1_rdata  (m1_rdata_o)
  );

endmodule

// File: doc/instr_ram_arbiter.md
Name: instr_ram_arbiter

Overview:
Shares the single-port instruction RAM/boot-ROM wrapper between two requesters: port 0 (core instruction fetch) and port 1 (program loader/debug, e.g. SPI/AXI bridge). Fixed priority to port 0, with a starvation counter that forces a port-1 grant after MAX_WAIT lost cycles. A lock input lets the loader exclude the core during program download. Sits between the requesters and the instruction RAM wrapper, which has 1-cycle read latency.

Parameters:
ADDR_WIDTH, 16, byte address width passed to the RAM wrapper (RAM bits + 1 boot-select bit)
DATA_WIDTH, 32, data width; be width is DATA_WIDTH/8
MAX_WAIT, 4, cycles port 1 may lose before it is forced to win; 0 = port 1 strict priority
CNT_WIDTH, 3, wait counter width; must hold MAX_WAIT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
m0_req_i  in  1  fetch request
m0_gnt_o  out  1  fetch grant (combinational, same cycle)
m0_addr_i  in  ADDR_WIDTH  fetch address
m0_rvalid_o  out  1  fetch response valid, 1 cycle after grant
m0_rdata_o  out  DATA_WIDTH  fetch read data
m1_req_i  in  1  loader request
m1_gnt_o  out  1  loader grant
m1_addr_i  in  ADDR_WIDTH  loader address
m1_we_i  in  1  loader write enable
m1_be_i  in  DATA_WIDTH/8  loader byte enables
m1_wdata_i  in  DATA_WIDTH  loader write data
m1_lock_i  in  1  loader lock: blocks all port-0 grants
m1_rvalid_o  out  1  loader response valid (reads and writes)
m1_rdata_o  out  DATA_WIDTH  loader read data
ram_en_o  out  1  RAM enable
ram_addr_o  out  ADDR_WIDTH  RAM address
ram_we_o  out  1  RAM write enable
ram_be_o  out  DATA_WIDTH/8  RAM byte enables
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o

Behaviour:
- Reset (rst high, async): wait_cnt=0, owner_q=0, valid_q=0. While rst is high, both gnt, ram_en_o, and both rvalid are 0.
- Grant decision, combinational each cycle:
  - force1 = m1_req_i & (m1_lock_i | wait_cnt >= MAX_WAIT).
  - m1_gnt_o = m1_req_i & (force1 | ~m0_req_i).
  - m0_gnt_o = m0_req_i & ~m1_lock_i & ~m1_gnt_o.
  - At most one grant per cycle.
- RAM side:
  - ram_en_o = m0_gnt_o | m1_gnt_o.
  - addr/we/be/wdata are muxed from the winner. For port 0: we=0, be=all ones, wdata=0.
  - When idle, RAM outputs hold port-0 values with en=0.
- Response pipeline:
  - valid_q <= ram_en_o; owner_q <= m1_gnt_o.
  - mX_rvalid_o = valid_q & (owner_q == X).
  - mX_rdata_o = ram_rdata_i when that port's rvalid is high, else 0.
  - Back-to-back grants are supported every cycle; no outstanding limit beyond 1 (fixed latency).
- Wait counter:
  - Increments (saturating at all ones) when m1_req_i & ~m1_gnt_o.
  - Cleared when m1_gnt_o, or when m1_req_i=0.
- Lock: while m1_lock_i=1, port 0 is never granted, even if port 1 is idle. Port-0 requests already granted still receive their rvalid.
- Request de-assertion: requesters keep req/addr stable until gnt. The arbiter does not check this; SVA in the bench does.
- Reset mid-transaction: any pending rvalid is dropped. No response is issued after reset.

Decomposition:
- Package instr_ram_arb_pkg: owner enum (OWNER_FETCH=0, OWNER_LOADER=1) and a request struct (addr, we, be, wdata).
- One natural sub-module, instr_ram_arb_resp: the valid_q/owner_q response register and rdata/rvalid demux.
- Grant logic and wait counter stay in the top.

Test Plan:
- Reset release, no requests -> all gnt/rvalid/ram_en_o 0; wait_cnt 0.
- m0 reads addr 0x0100 with RAM returning 0xDEADBEEF -> m0_gnt same cycle; m0_rvalid next cycle with rdata 0xDEADBEEF; m1_rvalid 0.
- m1 write addr 0x0040, be=4'b0011, wdata 0x12345678, m0 idle -> ram_we_o=1, be=0011 same cycle; m1_rvalid next cycle.
- m0 and m1 request continuously, MAX_WAIT=4 -> m0 wins cycles 0-3; m1 wins cycle 4; counter clears; pattern repeats 4:1.
- m1_lock_i=1, m0_req=1, m1_req=0 -> no grants. m1_req raised -> m1 granted immediately.
- rst asserted the cycle after an m0 grant -> m0_rvalid never asserts; all outputs 0 asynchronously.
